// File: rtl/adf4158_pkg.sv
// Shared definitions for the ADF4158 register sequencer: addresses, field layout, FSM states,
// and the word packer used by both the RTL and the bench reference.
package adf4158_pkg;

  localparam int unsigned SEQ_LEN = 10;

  localparam logic [2:0] R0_ADDR = 3'd0;
  localparam logic [2:0] R1_ADDR = 3'd1;
  localparam logic [2:0] R2_ADDR = 3'd2;
  localparam logic [2:0] R3_ADDR = 3'd3;
  localparam logic [2:0] R4_ADDR = 3'd4;
  localparam logic [2:0] R5_ADDR = 3'd5;
  localparam logic [2:0] R6_ADDR = 3'd6;
  localparam logic [2:0] R7_ADDR = 3'd7;

  localparam int unsigned CTRL_W       = 3;
  localparam int unsigned INT_LSB      = 15;
  localparam int unsigned INT_W        = 12;
  localparam int unsigned FRACMSB_LSB  = 3;
  localparam int unsigned FRACMSB_W    = 12;
  localparam int unsigned FRACLSB_LSB  = 15;
  localparam int unsigned FRACLSB_W    = 13;
  localparam int unsigned MUX_LSB      = 27;
  localparam int unsigned RAMP_EN_BIT  = 31;
  localparam int unsigned CP_LSB       = 24;
  localparam int unsigned PRESC_BIT    = 22;
  localparam int unsigned RDIV2_BIT    = 21;
  localparam int unsigned DBL_BIT      = 20;
  localparam int unsigned RCNT_LSB     = 15;
  localparam int unsigned CLK1_LSB     = 3;
  localparam int unsigned RMODE_LSB    = 10;
  localparam int unsigned CLKMODE_LSB  = 19;
  localparam int unsigned CLK2_LSB     = 7;
  localparam int unsigned DEV_LSB      = 3;
  localparam int unsigned DEVOFF_LSB   = 19;
  localparam int unsigned SEL_BIT      = 23;
  localparam int unsigned STEP_LSB     = 3;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DONE} state_t;

  // Run-time chirp configuration
  typedef struct packed {
    logic [11:0] int_div;
    logic [24:0] frac;
    logic [4:0]  rcnt;
    logic [11:0] clk1_div;
    logic [11:0] clk2_div;
    logic [1:0]  ramp_mode;
    logic        ramp_en;
    logic [15:0] dev0;
    logic [15:0] dev1;
    logic [3:0]  dev_off;
    logic [19:0] step0;
    logic [19:0] step1;
  } cfg_t;

  // Build-time device settings
  typedef struct packed {
    logic [3:0] cp_current;
    logic       prescaler;
    logic       ref_doubler;
    logic       rdiv2;
    logic [3:0] muxout;
    logic [1:0] clk_div_mode;
  } static_t;

  // Word for sequence slot idx: R7, R6 x2, R5 x2, R4, R3, R2, R1, R0
  function automatic logic [31:0] pack_word(input logic [3:0] idx, input cfg_t cfg,
                                            input static_t st);
    logic [31:0] w;
    w = '0;
    case (idx)
      4'd0: w[CTRL_W-1:0] = R7_ADDR;
      4'd1, 4'd2: begin
        w[SEL_BIT]           = (idx == 4'd2);
        w[STEP_LSB +: 20]    = (idx == 4'd2) ? cfg.step1 : cfg.step0;
        w[CTRL_W-1:0]        = R6_ADDR;
      end
      4'd3, 4'd4: begin
        w[SEL_BIT]           = (idx == 4'd4);
        w[DEVOFF_LSB +: 4]   = cfg.dev_off;
        w[DEV_LSB +: 16]     = (idx == 4'd4) ? cfg.dev1 : cfg.dev0;
        w[CTRL_W-1:0]        = R5_ADDR;
      end
      4'd5: begin
        w[CLKMODE_LSB +: 2]  = st.clk_div_mode;
        w[CLK2_LSB +: 12]    = cfg.clk2_div;
        w[CTRL_W-1:0]        = R4_ADDR;
      end
      4'd6: begin
        w[RMODE_LSB +: 2]    = cfg.ramp_mode;
        w[CTRL_W-1:0]        = R3_ADDR;
      end
      4'd7: begin
        w[CP_LSB +: 4]       = st.cp_current;
        w[PRESC_BIT]         = st.prescaler;
        w[RDIV2_BIT]         = st.rdiv2;
        w[DBL_BIT]           = st.ref_doubler;
        w[RCNT_LSB +: 5]     = cfg.rcnt;
        w[CLK1_LSB +: 12]    = cfg.clk1_div;
        w[CTRL_W-1:0]        = R2_ADDR;
      end
      4'd8: begin
        w[FRACLSB_LSB +: FRACLSB_W] = cfg.frac[12:0];
        w[CTRL_W-1:0]               = R1_ADDR;
      end
      4'd9: begin
        w[RAMP_EN_BIT]              = cfg.ramp_en;
        w[MUX_LSB +: 4]             = st.muxout;
        w[INT_LSB +: INT_W]         = cfg.int_div;
        w[FRACMSB_LSB +: FRACMSB_W] = cfg.frac[24:13];
        w[CTRL_W-1:0]               = R0_ADDR;
      end
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/adf4158_reg_sequencer_if.sv
// Word handshake between the register sequencer and the 3-wire serial shifter.
interface adf4158_reg_sequencer_if;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;

  modport master (output word_data, output word_valid, input word_ready);
  modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/adf4158_word_builder.sv
// Combinational slot-index + config to ADF4158 register word.
module adf4158_word_builder
  import adf4158_pkg::*;
(
  input  logic [3:0]  i_idx,
  input  cfg_t        i_cfg,
  input  static_t     i_st,
  output logic [31:0] o_word_c
);

  // Word packing lives in the package so it has a single definition
  always_comb o_word_c = pack_word(i_idx, i_cfg, i_st);

endmodule

// File: rtl/adf4158_reg_sequencer.sv
// ADF4158 register sequencer: one pass of ten register words per accepted start, R0 last.
// Optional build macro ADF4158_CFG_SHADOW_EN: capture cfg_* on the accepted start and build
// every word of the pass from that snapshot.
module adf4158_reg_sequencer
  import adf4158_pkg::*;
#(
  parameter logic [3:0] CP_CURRENT   = 4'd7,
  parameter logic       PRESCALER    = 1'b1,
  parameter logic       REF_DOUBLER  = 1'b0,
  parameter logic       RDIV2        = 1'b0,
  parameter logic [3:0] MUXOUT       = 4'd0,
  parameter logic [1:0] CLK_DIV_MODE = 2'd3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [11:0] cfg_int,
  input  logic [24:0] cfg_frac,
  input  logic [4:0]  cfg_rcnt,
  input  logic [11:0] cfg_clk1_div,
  input  logic [11:0] cfg_clk2_div,
  input  logic [1:0]  cfg_ramp_mode,
  input  logic        cfg_ramp_en,
  input  logic [15:0] cfg_dev0,
  input  logic [15:0] cfg_dev1,
  input  logic [3:0]  cfg_dev_off,
  input  logic [19:0] cfg_step0,
  input  logic [19:0] cfg_step1,
  adf4158_reg_sequencer_if.master wbus,
  output logic        busy,
  output logic        done,
  output logic [3:0]  word_idx
);

  localparam logic [3:0] LAST_IDX = 4'(SEQ_LEN - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_idx, w_idx_nxt;
  logic        r_valid, r_busy, r_done;
  logic [31:0] r_data;
  logic        w_valid_nxt, w_busy_nxt, w_done_nxt;
  logic [31:0] w_data_nxt, w_word;
  logic        w_xfer;
  cfg_t        w_cfg_live, w_cfg;
  static_t     w_st;

  assign w_cfg_live = '{int_div: cfg_int, frac: cfg_frac, rcnt: cfg_rcnt,
                        clk1_div: cfg_clk1_div, clk2_div: cfg_clk2_div,
                        ramp_mode: cfg_ramp_mode, ramp_en: cfg_ramp_en,
                        dev0: cfg_dev0, dev1: cfg_dev1, dev_off: cfg_dev_off,
                        step0: cfg_step0, step1: cfg_step1};
  assign w_st = '{cp_current: CP_CURRENT, prescaler: PRESCALER, ref_doubler: REF_DOUBLER,
                  rdiv2: RDIV2, muxout: MUXOUT, clk_div_mode: CLK_DIV_MODE};
  assign w_xfer = r_valid & wbus.word_ready;

`ifdef ADF4158_CFG_SHADOW_EN
  cfg_t r_cfg;

  // Snapshot config on the accepted start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             r_cfg <= '0;
    else if (r_state == ST_IDLE && start)     r_cfg <= w_cfg_live;
  end

  // Word 0 is built on the start edge itself, before the snapshot is visible
  assign w_cfg = (r_state == ST_IDLE) ? w_cfg_live : r_cfg;
`else
  assign w_cfg = w_cfg_live;
`endif

  adf4158_word_builder u_builder (
    .i_idx    (w_idx_nxt),
    .i_cfg    (w_cfg),
    .i_st     (w_st),
    .o_word_c (w_word)
  );

  // State and word index register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state: advance one slot per transfer, leave after the R0 transfer
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE: if (start) begin
        w_state_nxt = ST_ISSUE;
        w_idx_nxt   = '0;
      end
      ST_ISSUE: if (w_xfer) begin
        if (r_idx == LAST_IDX) begin
          w_state_nxt = ST_DONE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt   = r_idx + 4'd1;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state; data forced to zero when not valid
  always_comb begin
    w_valid_nxt = (w_state_nxt == ST_ISSUE);
    w_busy_nxt  = (w_state_nxt == ST_ISSUE);
    w_done_nxt  = (w_state_nxt == ST_DONE);
    w_data_nxt  = w_valid_nxt ? w_word : '0;
  end

  // Output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_data  <= w_data_nxt;
    end
  end

  assign wbus.word_data  = r_data;
  assign wbus.word_valid = r_valid;
  assign busy            = r_busy;
  assign done            = r_done;
  assign word_idx        = r_idx;

endmodule

// File: tb/tb_adf4158_reg_sequencer.sv
// Directed, table-driven bench for adf4158_reg_sequencer.
module tb_adf4158_reg_sequencer;
  import adf4158_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] cfg_int = '0;
  logic [24:0] cfg_frac = '0;
  logic [4:0]  cfg_rcnt = '0;
  logic [11:0] cfg_clk1_div = '0;
  logic [11:0] cfg_clk2_div = '0;
  logic [1:0]  cfg_ramp_mode = '0;
  logic        cfg_ramp_en = 1'b0;
  logic [15:0] cfg_dev0 = '0;
  logic [15:0] cfg_dev1 = '0;
  logic [3:0]  cfg_dev_off = '0;
  logic [19:0] cfg_step0 = '0;
  logic [19:0] cfg_step1 = '0;
  logic        busy, done;
  logic [3:0]  word_idx;

  adf4158_reg_sequencer_if bus ();

  adf4158_reg_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .cfg_int(cfg_int), .cfg_frac(cfg_frac), .cfg_rcnt(cfg_rcnt),
    .cfg_clk1_div(cfg_clk1_div), .cfg_clk2_div(cfg_clk2_div),
    .cfg_ramp_mode(cfg_ramp_mode), .cfg_ramp_en(cfg_ramp_en),
    .cfg_dev0(cfg_dev0), .cfg_dev1(cfg_dev1), .cfg_dev_off(cfg_dev_off),
    .cfg_step0(cfg_step0), .cfg_step1(cfg_step1),
    .wbus(bus.master), .busy(busy), .done(done), .word_idx(word_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        ready;
    logic        valid;
    logic        busy;
    logic        done;
    logic [3:0]  idx;
    logic [31:0] data;
  } vec_t;

  vec_t        vecs[$];
  int          checks = 0;
  int          errors = 0;
  int          xfer_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] exp_a [10];
  logic [31:0] exp_b [10];
  logic        pat [4];

  // Count handshakes and done pulses as the serializer would see them
  always @(posedge clk) begin
    if (bus.word_valid && bus.word_ready) xfer_cnt++;
    if (done) done_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_cfg_a();
    cfg_int = 12'd100;     cfg_frac = 25'h1000001; cfg_rcnt = 5'd1;
    cfg_clk1_div = 12'h00A; cfg_clk2_div = 12'h005; cfg_ramp_mode = 2'd1;
    cfg_ramp_en = 1'b1;    cfg_dev0 = 16'hFFFF;    cfg_dev1 = 16'h0010;
    cfg_dev_off = 4'd9;    cfg_step0 = 20'h00100;  cfg_step1 = 20'hFFFFF;
  endtask

  task automatic set_cfg_b();
    cfg_int = 12'hFFF;     cfg_frac = 25'h1FFFFFF; cfg_rcnt = 5'd0;
    cfg_clk1_div = 12'h000; cfg_clk2_div = 12'h000; cfg_ramp_mode = 2'd0;
    cfg_ramp_en = 1'b0;    cfg_dev0 = 16'h8000;    cfg_dev1 = 16'h0000;
    cfg_dev_off = 4'hF;    cfg_step0 = 20'h0;      cfg_step1 = 20'h0;
  endtask

  // mode 0: ready always 1; mode 1: ready 1-0-0-1 cycling; mode 2: mode 0 plus stray starts
  task automatic build(input logic [31:0] exp [10], input int mode);
    vec_t v;
    int   idx;
    int   k;
    logic r;
    vecs.delete();
    idx = 0;
    k = 0;
    while (idx < 10) begin
      r = (mode == 1) ? pat[k % 4] : 1'b1;
      v.start = (mode == 2 && k == 3);
      v.ready = r; v.valid = 1'b1; v.busy = 1'b1; v.done = 1'b0;
      v.idx = 4'(idx); v.data = exp[idx];
      vecs.push_back(v);
      if (r) idx++;
      k++;
    end
    v.start = (mode == 2); v.ready = 1'b1; v.valid = 1'b0; v.busy = 1'b0; v.done = 1'b1;
    v.idx = 4'd0; v.data = 32'h0;
    vecs.push_back(v);
    v.start = 1'b0; v.done = 1'b0;
    vecs.push_back(v);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    bus.word_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vectors(input string tag);
    vec_t v;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      chk($sformatf("%s r%0d valid", tag, i), 32'(bus.word_valid), 32'(v.valid));
      chk($sformatf("%s r%0d busy", tag, i), 32'(busy), 32'(v.busy));
      chk($sformatf("%s r%0d done", tag, i), 32'(done), 32'(v.done));
      chk($sformatf("%s r%0d data", tag, i), bus.word_data, v.data);
      if (v.valid) chk($sformatf("%s r%0d idx", tag, i), 32'(word_idx), 32'(v.idx));
      start = v.start;
      bus.word_ready = v.ready;
      @(negedge clk);
    end
    start = 1'b0;
    bus.word_ready = 1'b0;
  endtask

  initial begin
    int   x0;
    int   d0;
    int   n;
    logic seen;

    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    exp_a = '{32'h0000_0007, 32'h0000_0806, 32'h00FF_FFFE, 32'h004F_FFFD, 32'h00C8_0085,
              32'h0018_0284, 32'h0000_0403, 32'h0740_8052, 32'h0000_8001, 32'h8032_4000};
    exp_b = '{32'h0000_0007, 32'h0000_0006, 32'h0080_0006, 32'h007C_0005, 32'h00F8_0005,
              32'h0018_0004, 32'h0000_0003, 32'h0740_0002, 32'h0FFF_8001, 32'h07FF_FFF8};
    bus.word_ready = 1'b0;

    // Reset values
    #1;
    chk("reset valid", 32'(bus.word_valid), 32'h0);
    chk("reset data", bus.word_data, 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset done", 32'(done), 32'h0);
    chk("reset idx", 32'(word_idx), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Back-to-back pass with config A
    set_cfg_a();
    build(exp_a, 0);
    do_start();
    run_vectors("a_b2b");

    // Stalled handshake, same config
    build(exp_a, 1);
    do_start();
    run_vectors("a_stall");

    // Config B: max INT/FRAC, negative deviation, ramp off
    set_cfg_b();
    build(exp_b, 0);
    do_start();
    run_vectors("b_b2b");

    // Starts while busy and on the done cycle are ignored
    set_cfg_a();
    build(exp_a, 2);
    x0 = xfer_cnt;
    d0 = done_cnt;
    do_start();
    run_vectors("a_restart");
    chk("restart transfers", 32'(xfer_cnt - x0), 32'd10);
    chk("restart done pulses", 32'(done_cnt - d0), 32'd1);

    // Reset mid-pass at idx 4, then a full pass
    do_start();
    bus.word_ready = 1'b1;
    for (n = 0; n < 30 && word_idx != 4'd4; n++) @(negedge clk);
    chk("abort reached idx4", 32'(word_idx), 32'd4);
    reset_n = 1'b0;
    #1;
    chk("abort valid", 32'(bus.word_valid), 32'h0);
    chk("abort data", bus.word_data, 32'h0);
    chk("abort busy", 32'(busy), 32'h0);
    chk("abort done", 32'(done), 32'h0);
    chk("abort idx", 32'(word_idx), 32'h0);
    chk("abort state", 32'(dut.r_state), 32'(ST_IDLE));
    bus.word_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    build(exp_a, 0);
    do_start();
    run_vectors("a_after_abort");

    // INT changed mid-pass: snapshot build keeps the original, live build follows
    do_start();
    bus.word_ready = 1'b1;
    seen = 1'b0;
    for (n = 0; n < 30 && !seen; n++) begin
      if (bus.word_valid && word_idx == 4'd4) cfg_int = 12'd200;
      if (bus.word_valid && word_idx == 4'd9) begin
`ifdef ADF4158_CFG_SHADOW_EN
        chk("midpass R0", bus.word_data, 32'h8032_4000);
`else
        chk("midpass R0", bus.word_data, 32'h8064_4000);
`endif
        seen = 1'b1;
      end
      @(negedge clk);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL midpass R0: got no idx9 word, expected one within 30 cycles");
    end
    bus.word_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("midpass idle busy", 32'(busy), 32'h0);
    cfg_int = 12'd100;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
